// File: rtl/mem_access_unit.sv
// MEM-stage data-cache access unit: one outstanding request, store lane
// replication/byte enables, load lane selection and sign/zero extension.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic        read_q, write_q, done_q, misalign_q, store_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        req, legal;
  logic [31:0] st_wdata_d;
  logic [3:0]  st_be_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data_d;

  assign req = valid_i & (mem_read_i | mem_write_i);

  // mem_write_i alone decides store legality since write wins over read
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_i[0];
      3'b010:  legal = (addr_i[1:0] == 2'b00);
      3'b100:  legal = ~mem_write_i;
      3'b101:  legal = ~mem_write_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata_d = wdata_i;
    st_be_d    = 4'b1111;
    if (mem_write_i) begin
      case (funct3_i)
        3'b000: begin
          st_wdata_d = {4{wdata_i[7:0]}};
          st_be_d    = 4'b0001 << addr_i[1:0];
        end
        3'b001: begin
          st_wdata_d = {2{wdata_i[15:0]}};
          st_be_d    = 4'b0011 << addr_i[1:0];
        end
        default: begin
          st_wdata_d = wdata_i;
          st_be_d    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lane_q)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data_d = {24'b0, ld_byte};
      3'b101:  ld_data_d = {16'b0, ld_half};
      default: ld_data_d = dmem_rdata;
    endcase
    if (store_q) ld_data_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      load_q     <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && legal) begin
            read_q   <= ~mem_write_i;
            write_q  <= mem_write_i;
            store_q  <= mem_write_i;
            addr_q   <= {addr_i[31:2], 2'b00};
            wdata_q  <= st_wdata_d;
            be_q     <= st_be_d;
            funct3_q <= funct3_i;
            lane_q   <= addr_i[1:0];
            state_q  <= BUSY;
          end else if (req) begin
            misalign_q <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            load_q  <= ld_data_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign load_data_o      = load_q;
  assign done_o           = done_q;
  assign misalign_o       = misalign_q;
  assign stall_o          = req & legal & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, illegal accesses, reset.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data_o;
  logic        done_o, stall_o, misalign_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        stall0;
    logic        rd1;
    logic        wr1;
    logic [31:0] ad1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [31:0] ad_late;
    logic [7:0]  req_cycles;
    logic        stall_busy;
    logic        done_seen;
    logic [31:0] ld;
    logic        stall_done;
    logic        done_after;
  } res_t;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .load_data_o(load_data_o), .done_o(done_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // Drives one access (inputs perturbed while busy) and records what the unit did.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int unsigned d,
                            output res_t r);
    r = '0;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    r.stall0 = stall_o;
    @(posedge clk); #1;
    r.rd1 = dmem_read; r.wr1 = dmem_write;
    r.ad1 = dmem_address; r.wd1 = dmem_wdata; r.be1 = dmem_byte_enable;
    r.stall_busy = 1'b1;
    for (int unsigned i = 0; i < d; i++) begin
      if (dmem_read | dmem_write) r.req_cycles++;
      r.stall_busy &= stall_o;
      addr_i = a ^ 32'h0000_0F00;
      wdata_i = ~wd;
      @(posedge clk); #1;
    end
    if (dmem_read | dmem_write) r.req_cycles++;
    r.stall_busy &= stall_o;
    r.ad_late = dmem_address;
    dmem_rdata = rdat; dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    r.done_seen = done_o; r.ld = load_data_o; r.stall_done = stall_o;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(posedge clk); #1;
    r.done_after = done_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'b000; addr_i = '0; wdata_i = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", dmem_read); end
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", dmem_write); end
    checks++; if (dmem_byte_enable !== 4'h0) begin errors++; $display("FAIL reset_be: got %h expected 0", dmem_byte_enable); end
    checks++; if (dmem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", dmem_address); end
    checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", load_data_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    res_t r;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, r);
    checks++; if (r.stall0 !== 1'b1) begin errors++; $display("FAIL lw_stall_accept: got %b expected 1", r.stall0); end
    checks++; if ({r.rd1, r.wr1} !== 2'b10) begin errors++; $display("FAIL lw_req: got %b expected 10", {r.rd1, r.wr1}); end
    checks++; if (r.ad1 !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h expected 00000100", r.ad1); end
    checks++; if (r.be1 !== 4'hF) begin errors++; $display("FAIL lw_be: got %h expected f", r.be1); end
    checks++; if (r.req_cycles !== 8'd3) begin errors++; $display("FAIL lw_read_cycles: got %0d expected 3", r.req_cycles); end
    checks++; if (r.ad_late !== 32'h100) begin errors++; $display("FAIL lw_addr_hold: got %h expected 00000100", r.ad_late); end
    checks++; if (r.stall_busy !== 1'b1) begin errors++; $display("FAIL lw_stall_busy: got %b expected 1", r.stall_busy); end
    checks++; if (r.done_seen !== 1'b1) begin errors++; $display("FAIL lw_done: got %b expected 1", r.done_seen); end
    checks++; if (r.ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", r.ld); end
    checks++; if (r.stall_done !== 1'b0) begin errors++; $display("FAIL lw_stall_done: got %b expected 0", r.stall_done); end
    checks++; if (r.done_after !== 1'b0) begin errors++; $display("FAIL lw_done_once: got %b expected 0", r.done_after); end
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL lw_read_drop: got %b expected 0", dmem_read); end
  endtask

  task automatic test_byte_half_loads();
    res_t r;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, r);
    checks++; if (r.ld !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_103: got %h expected ffffff80", r.ld); end
    checks++; if (r.ad1 !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", r.ad1); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, r);
    checks++; if (r.ld !== 32'h0000_0080) begin errors++; $display("FAIL lbu_103: got %h expected 00000080", r.ld); end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, r);
    checks++; if (r.ld !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_102: got %h expected ffff8001", r.ld); end
    run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001_1234, 0, r);
    checks++; if (r.ld !== 32'h0000_1234) begin errors++; $display("FAIL lhu_100: got %h expected 00001234", r.ld); end
    run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 0, r);
    checks++; if (r.ld !== 32'h0000_007F) begin errors++; $display("FAIL lb_101_pos: got %h expected 0000007f", r.ld); end
  endtask

  task automatic test_stores();
    res_t r;
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'hFFFF_FFFF, 0, r);
    checks++; if ({r.rd1, r.wr1} !== 2'b01) begin errors++; $display("FAIL sb_req: got %b expected 01", {r.rd1, r.wr1}); end
    checks++; if (r.wd1 !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", r.wd1); end
    checks++; if (r.be1 !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", r.be1); end
    checks++; if (r.ad1 !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h expected 00000200", r.ad1); end
    checks++; if (r.ld !== 32'h0) begin errors++; $display("FAIL sb_load_zero: got %h expected 00000000", r.ld); end
    checks++; if (r.done_seen !== 1'b1) begin errors++; $display("FAIL sb_done: got %b expected 1", r.done_seen); end
    // read and write together: the write wins
    run_access(1'b1, 1'b1, 3'b001, 32'h202, 32'h5555_1234, 32'h0, 1, r);
    checks++; if ({r.rd1, r.wr1} !== 2'b01) begin errors++; $display("FAIL sh_rw_req: got %b expected 01", {r.rd1, r.wr1}); end
    checks++; if (r.be1 !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", r.be1); end
    checks++; if (r.wd1 !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h expected 12341234", r.wd1); end
    run_access(1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'h0, 2, r);
    checks++; if (r.be1 !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", r.be1); end
    checks++; if (r.ad1 !== 32'h200) begin errors++; $display("FAIL sw_addr: got %h expected 00000200", r.ad1); end
    checks++; if (r.wd1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_wdata: got %h expected cafef00d", r.wd1); end
    checks++; if (r.req_cycles !== 8'd3) begin errors++; $display("FAIL sw_write_cycles: got %0d expected 3", r.req_cycles); end
  endtask

  task automatic test_illegal();
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin rd = 1'b1; wr = 1'b0; f3 = 3'b010; a = 32'h101; end
        1:       begin rd = 1'b0; wr = 1'b1; f3 = 3'b001; a = 32'h203; end
        default: begin rd = 1'b0; wr = 1'b1; f3 = 3'b100; a = 32'h200; end
      endcase
      valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL illegal%0d_stall: got %b expected 0", i, stall_o); end
      @(posedge clk); #1;
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL illegal%0d_misalign: got %b expected 1", i, misalign_o); end
      checks++; if ({dmem_read, dmem_write} !== 2'b00) begin errors++; $display("FAIL illegal%0d_req: got %b expected 00", i, {dmem_read, dmem_write}); end
      @(posedge clk); #1;
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL illegal%0d_pulse: got %b expected 0", i, misalign_o); end
    end
  endtask

  task automatic test_idle_resp();
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = '0;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL idle_resp_done: got %b expected 0", done_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL idle_resp_done2: got %b expected 0", done_o); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 0, r);
    checks++; if (r.done_seen !== 1'b1 || r.ld !== 32'h1111_2222) begin errors++; $display("FAIL b2b_first: got done=%b data=%h expected done=1 data=11112222", r.done_seen, r.ld); end
    checks++; if (r.stall_done !== 1'b0) begin errors++; $display("FAIL b2b_stall_fall: got %b expected 0", r.stall_done); end
    run_access(1'b0, 1'b1, 3'b000, 32'h403, 32'h0000_005A, 32'h0, 0, r);
    checks++; if (r.be1 !== 4'b1000 || r.ad1 !== 32'h400) begin errors++; $display("FAIL b2b_second: got be=%b addr=%h expected be=1000 addr=00000400", r.be1, r.ad1); end
    checks++; if (r.done_seen !== 1'b1 || r.ld !== 32'h0) begin errors++; $display("FAIL b2b_second_done: got done=%b data=%h expected done=1 data=00000000", r.done_seen, r.ld); end
  endtask

  task automatic test_reset_mid_busy();
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    @(posedge clk); #1;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rst_busy_read: got %b expected 1", dmem_read); end
    rst = 1'b0;
    valid_i = 1'b0; mem_read_i = 1'b0;
    #1;
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL rst_busy_read_clr: got %b expected 0", dmem_read); end
    checks++; if (dmem_address !== 32'h0 || dmem_byte_enable !== 4'h0) begin errors++; $display("FAIL rst_busy_req_clr: got addr=%h be=%h expected 0", dmem_address, dmem_byte_enable); end
    @(negedge clk) rst = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'hFACE_FACE;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = '0;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_late_resp_done: got %b expected 0", done_o); end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL rst_late_resp_data: got %h expected 00000000", load_data_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0 || dmem_read !== 1'b0) begin errors++; $display("FAIL rst_late_after: got done=%b read=%b expected 0 0", done_o, dmem_read); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_illegal();
    test_idle_resp();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit for the pipelined RV32I core. It consumes the `mem_read`/`mem_write` bits and `funct3` of the control word at the MEM stage and drives a single outstanding request on the data-cache port. It generates byte enables and lane-replicated store data, and sign- or zero-extends load data. It holds the pipeline stalled until the cache responds.

## Interface
Parameters:
- none (32-bit data and address fixed by RV32I)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  MEM-stage instruction valid
- `mem_read_i`  in  1  control-word load request
- `mem_write_i`  in  1  control-word store request
- `funct3_i`  in  3  load/store width: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `addr_i`  in  32  effective address (ALU output)
- `wdata_i`  in  32  store source (rs2 value)
- `dmem_read`  out  1  cache read request (registered)
- `dmem_write`  out  1  cache write request (registered)
- `dmem_address`  out  32  word-aligned address, `{addr[31:2],2'b00}` (registered)
- `dmem_wdata`  out  32  lane-replicated store data (registered)
- `dmem_byte_enable`  out  4  write byte mask (registered)
- `dmem_rdata`  in  32  cache read data, valid with `dmem_resp`
- `dmem_resp`  in  1  one-cycle completion pulse
- `load_data_o`  out  32  extended load result, valid while `done_o`=1
- `done_o`  out  1  access completed this cycle
- `stall_o`  out  1  combinational; freeze upstream pipeline
- `misalign_o`  out  1  one-cycle pulse: misaligned access or illegal funct3, no access issued

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: the unit accepts an access when `valid_i & (mem_read_i|mem_write_i)`.
  - If the access is legal, it latches funct3, `addr[1:0]` and the request type. It sets the registered `dmem_*` outputs and moves to BUSY.
  - If the access is illegal, it pulses `misalign_o` next cycle, stays in IDLE and issues no cache request.
- Legality rules:
  - h/hu requires `addr[0]`=0.
  - w requires `addr[1:0]`=0.
  - funct3 011, 110 and 111 are illegal.
  - Stores with 100 or 101 are illegal.
- If read and write are both set, write wins and the read is ignored.
- BUSY: requests are held stable until `dmem_resp`. On `dmem_resp` the unit does the following, then moves to DONE:
  - drops `dmem_read` and `dmem_write`
  - registers `load_data_o`
  - sets `done_o`=1
- DONE: lasts one cycle with `done_o`=1. The pipeline advances on this edge, then the FSM returns to IDLE. A new access is accepted only from IDLE.
- Store encoding:
  - sb: `dmem_wdata={4{wdata[7:0]}}`, `byte_enable=4'b0001<<addr[1:0]`
  - sh: `dmem_wdata={2{wdata[15:0]}}`, `byte_enable=4'b0011<<addr[1:0]`
  - sw: `dmem_wdata=wdata`, `byte_enable=4'b1111`
- Load encoding: `byte_enable=4'b1111`. Byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - lb/lh: sign-extend the selected lane.
  - lbu/lhu: zero-extend the selected lane.
  - lw: pass through unchanged.
- `load_data_o` is 0 after a store completes.
- `stall_o = valid_i & (mem_read_i|mem_write_i) & legal & (state != DONE)`.

## Timing
- Reset (`rst`=0, asynchronous) takes effect immediately:
  - state is IDLE
  - `dmem_read`, `dmem_write` and `dmem_byte_enable` are 0
  - `dmem_address` and `dmem_wdata` are 0
  - `load_data_o`, `done_o` and `misalign_o` are 0
- Reset mid-BUSY abandons the request. A late `dmem_resp` arriving after reset is ignored.
- Minimum latency:
  - accept in cycle 0
  - `dmem_read`/`dmem_write` high in cycle 1
  - if `dmem_resp` arrives in cycle 1, DONE is in cycle 2 and `stall_o` falls in cycle 2
- General case: `dmem_resp` in cycle k gives `done_o` in cycle k+1.
- `dmem_resp` in IDLE or DONE is ignored.
- Request outputs never change while in BUSY, regardless of input changes.
- `misalign_o` is high exactly one cycle, the cycle after the illegal access is seen in IDLE.
- `stall_o` is low during that illegal-access cycle.

## Test plan
- lw at 0x100, `dmem_resp` 3 cycles after request, rdata 0xDEADBEEF:
  - `dmem_read` held for 3 cycles, `dmem_address`=0x100
  - `done_o` one cycle with `load_data_o`=0xDEADBEEF
  - `stall_o` high until the DONE cycle
- lb at 0x103 and lbu at 0x103, rdata 0x80FF_0000 → `load_data_o`=0xFFFFFF80, then 0x00000080.
- lh at 0x102 with rdata 0x8001_1234 → 0xFFFF8001; lhu at 0x100 with the same rdata → 0x00001234.
- sb 0xAB at 0x201 → `dmem_wdata`=0xABABABAB, `byte_enable`=0010.
- sh at 0x202 → `byte_enable`=1100; sw → 1111 with `dmem_address`=0x200.
- Illegal accesses: lw at 0x101, sh at 0x203, store with funct3 100 → `misalign_o` pulse, no `dmem_read`/`dmem_write`, `stall_o`=0.
- Reset asserted mid-BUSY, then `dmem_resp` → all outputs 0 and `done_o` never asserts.
